// File: rtl/dbg_mon_pkg.sv
// Shared definitions for the core debug monitor: dump FSM encoding, frame constants
// and the MSB-first byte picker used when serialising 32-bit words.
package dbg_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_SNAP    = 3'd2,
        ST_REGSET  = 3'd3,
        ST_REGWAIT = 3'd4,
        ST_REGSEND = 3'd5,
        ST_CHK     = 3'd6,
        ST_DONE    = 3'd7
    } dump_state_e;

    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
    localparam int unsigned FRAME_BYTES = 142;
    localparam int unsigned NUM_REGS    = 32;
    localparam int unsigned SNAP_BYTES  = 12;

    // Byte idx of a word, idx 0 being the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    word_byte = word[31:24];
            2'd1:    word_byte = word[23:16];
            2'd2:    word_byte = word[15:8];
            default: word_byte = word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer. tx_ready is also high in the final stop-bit cycle so a
// waiting byte follows the previous one with no idle gap.
module uart_tx_byte #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_idle,
    output logic       tx_line
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic             active_q, active_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             line_q, line_d;
    logic             bit_end_s;
    logic             last_s;

    assign bit_end_s = active_q && (div_q == DIV_W'(CLK_DIV - 1));
    assign last_s    = bit_end_s && (bit_q == 4'd9);
    assign tx_ready  = ~active_q | last_s;
    assign tx_idle   = ~active_q;
    assign tx_line   = line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            shift_q  <= 9'h1FF;
            bit_q    <= 4'd0;
            div_q    <= DIV_W'(0);
            line_q   <= 1'b1;
        end else begin
            active_q <= active_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            line_q   <= line_d;
        end
    end

    // shift_q holds the bits still to go out ({stop, data}); the start bit is driven on load.
    always_comb begin
        active_d = active_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        div_d    = div_q;
        line_d   = line_q;
        if (tx_valid && tx_ready) begin
            active_d = 1'b1;
            shift_d  = {1'b1, tx_data};
            bit_d    = 4'd0;
            div_d    = DIV_W'(0);
            line_d   = 1'b0;
        end else if (last_s) begin
            active_d = 1'b0;
            div_d    = DIV_W'(0);
            line_d   = 1'b1;
        end else if (bit_end_s) begin
            div_d    = DIV_W'(0);
            bit_d    = bit_q + 4'd1;
            line_d   = shift_q[0];
            shift_d  = {1'b1, shift_q[8:1]};
        end else if (active_q) begin
            div_d    = div_q + DIV_W'(1);
        end else begin
            div_d    = DIV_W'(0);
        end
    end

endmodule

// File: rtl/core_debug_monitor.sv
// Host-side debug port controller: step pulser, halt-and-scan dump FSM, framed UART stream.
// Build option DBG_AUTO_DUMP_EN: every step pulse's falling edge requests a snapshot frame.
module core_debug_monitor
    import dbg_mon_pkg::*;
#(
    parameter int CLK_DIV   = 434,
    parameter int STEP_HIGH = 4,
    parameter int SETTLE    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        run_mode,
    input  logic        start_dump,
    input  logic [31:0] dbg_pc,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_reg,
    input  logic [31:0] dbg_inst,
    output logic        step,
    output logic        debug_mode,
    output logic [4:0]  debug_reg_addr,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int STEP_W = $clog2(STEP_HIGH + 1);
    localparam int SET_W  = $clog2(SETTLE + 1);

    dump_state_e       state_q, state_d;
    logic [1:0]        btn_sync_q;
    logic              btn_prev_q;
    logic              step_q, step_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              debug_mode_q, debug_mode_d;
    logic              busy_q, busy_d;
    logic [4:0]        addr_q, addr_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [3:0]        byte_idx_q, byte_idx_d;
    logic [4:0]        reg_idx_q, reg_idx_d;
    logic [SET_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0]       pc_q, pc_d, inst_q, inst_d, daddr_q, daddr_d, reg_q, reg_d;
    logic [7:0]        chk_q, chk_d;

    logic              btn_rise_s;
    logic              auto_req_s;
    logic              start_acc_s;
    logic              tx_valid_s;
    logic [7:0]        tx_data_s;
    logic              tx_ready_s;
    logic              tx_idle_s;
    logic              tx_fire_s;
    logic [31:0]       snap_word_s;

`ifdef DBG_AUTO_DUMP_EN
    logic              arm_q, arm_d;
    assign auto_req_s = arm_q;
`else
    assign auto_req_s = 1'b0;
`endif

    assign btn_rise_s  = btn_sync_q[1] & ~btn_prev_q;
    assign start_acc_s = (start_dump | auto_req_s) & ~busy_q & ~step_q & (state_q == ST_IDLE);
    assign tx_fire_s   = tx_valid_s & tx_ready_s;

    assign step           = step_q;
    assign debug_mode     = debug_mode_q;
    assign debug_reg_addr = addr_q;
    assign busy           = busy_q;
    assign frame_cnt      = frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync_q   <= 2'b00;
            btn_prev_q   <= 1'b0;
            step_q       <= 1'b0;
            step_cnt_q   <= STEP_W'(0);
            debug_mode_q <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= 5'd0;
            frame_cnt_q  <= 16'd0;
            byte_idx_q   <= 4'd0;
            reg_idx_q    <= 5'd0;
            wait_cnt_q   <= SET_W'(0);
            pc_q         <= 32'd0;
            inst_q       <= 32'd0;
            daddr_q      <= 32'd0;
            reg_q        <= 32'd0;
            chk_q        <= 8'd0;
`ifdef DBG_AUTO_DUMP_EN
            arm_q        <= 1'b0;
`endif
        end else begin
            btn_sync_q   <= {btn_sync_q[0], btn_step};
            btn_prev_q   <= btn_sync_q[1];
            step_q       <= step_d;
            step_cnt_q   <= step_cnt_d;
            debug_mode_q <= debug_mode_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            frame_cnt_q  <= frame_cnt_d;
            byte_idx_q   <= byte_idx_d;
            reg_idx_q    <= reg_idx_d;
            wait_cnt_q   <= wait_cnt_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            daddr_q      <= daddr_d;
            reg_q        <= reg_d;
            chk_q        <= chk_d;
`ifdef DBG_AUTO_DUMP_EN
            arm_q        <= arm_d;
`endif
        end
    end

    // Next state for the dump FSM, the step pulser and the run/halt control.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        addr_d      = addr_q;
        frame_cnt_d = frame_cnt_q;
        byte_idx_d  = byte_idx_q;
        reg_idx_d   = reg_idx_q;
        wait_cnt_d  = wait_cnt_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        daddr_d     = daddr_q;
        reg_d       = reg_q;
        chk_d       = chk_q;
        step_d      = step_q;
        step_cnt_d  = step_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_d = ST_SYNC;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (tx_fire_s) begin
                    state_d    = ST_SNAP;
                    pc_d       = dbg_pc;
                    inst_d     = dbg_inst;
                    daddr_d    = dbg_addr;
                    byte_idx_d = 4'd0;
                    chk_d      = 8'd0;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_SNAP: begin
                if (tx_fire_s) begin
                    chk_d = chk_q ^ tx_data_s;
                    if (byte_idx_q == 4'(SNAP_BYTES - 1)) begin
                        state_d   = ST_REGSET;
                        reg_idx_d = 5'd0;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_SNAP;
                end
            end
            ST_REGSET: begin
                addr_d     = reg_idx_q;
                wait_cnt_d = SET_W'(0);
                state_d    = ST_REGWAIT;
            end
            // dbg_reg is combinational on debug_reg_addr; give it SETTLE cycles before sampling.
            ST_REGWAIT: begin
                if (wait_cnt_q == SET_W'(SETTLE - 1)) begin
                    reg_d      = dbg_reg;
                    byte_idx_d = 4'd0;
                    state_d    = ST_REGSEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + SET_W'(1);
                end
            end
            ST_REGSEND: begin
                if (tx_fire_s) begin
                    chk_d = chk_q ^ tx_data_s;
                    if (byte_idx_q[1:0] == 2'd3) begin
                        if (reg_idx_q == 5'(NUM_REGS - 1)) begin
                            state_d = ST_CHK;
                        end else begin
                            reg_idx_d = reg_idx_q + 5'd1;
                            state_d   = ST_REGSET;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_REGSEND;
                end
            end
            ST_CHK: begin
                if (tx_fire_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CHK;
                end
            end
            ST_DONE: begin
                if (tx_idle_s) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    busy_d      = 1'b0;
                    addr_d      = 5'd0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                addr_d  = 5'd0;
            end
        endcase

        // Edges during a pulse or a frame are dropped; a dump accepted this cycle wins.
        if (step_q) begin
            if (step_cnt_q == STEP_W'(0)) begin
                step_d = 1'b0;
            end else begin
                step_cnt_d = step_cnt_q - STEP_W'(1);
            end
        end else if (btn_rise_s && !busy_q && !run_mode && !start_acc_s) begin
            step_d     = 1'b1;
            step_cnt_d = STEP_W'(STEP_HIGH - 1);
        end else begin
            step_d = 1'b0;
        end

        debug_mode_d = run_mode & ~busy_d & ~busy_q;
`ifdef DBG_AUTO_DUMP_EN
        arm_d = step_q & ~step_d;
`endif
    end

    // Byte mux feeding the serializer.
    always_comb begin
        tx_valid_s = 1'b0;
        tx_data_s  = 8'd0;
        case (byte_idx_q[3:2])
            2'd0:    snap_word_s = pc_q;
            2'd1:    snap_word_s = inst_q;
            default: snap_word_s = daddr_q;
        endcase
        case (state_q)
            ST_SYNC: begin
                tx_valid_s = 1'b1;
                tx_data_s  = SYNC_BYTE;
            end
            ST_SNAP: begin
                tx_valid_s = 1'b1;
                tx_data_s  = word_byte(snap_word_s, byte_idx_q[1:0]);
            end
            ST_REGSEND: begin
                tx_valid_s = 1'b1;
                tx_data_s  = word_byte(reg_q, byte_idx_q[1:0]);
            end
            ST_CHK: begin
                tx_valid_s = 1'b1;
                tx_data_s  = chk_q;
            end
            default: begin
                tx_valid_s = 1'b0;
                tx_data_s  = 8'd0;
            end
        endcase
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid_s),
        .tx_data  (tx_data_s),
        .tx_ready (tx_ready_s),
        .tx_idle  (tx_idle_s),
        .tx_line  (uart_tx)
    );

endmodule
